// File: rtl/derived_clock_monitor_if.sv
// Bundle of the derived-clock monitor control inputs and measurement results.
// The master modport drives clk_in/start/gate_len. The slave modport is the monitor.
interface derived_clock_monitor_if #(
    parameter int CW = 32
);
    logic          clk_in;
    logic          start;
    logic [CW-1:0] gate_len;
    logic          rise_stb;
    logic          fall_stb;
    logic          busy;
    logic          done;
    logic          timeout;
    logic          overflow;
    logic [CW-1:0] edge_count;
    logic [CW-1:0] period_last;
    logic [CW-1:0] period_min;
    logic [CW-1:0] period_max;

    modport master (
        output clk_in, start, gate_len,
        input  rise_stb, fall_stb, busy, done, timeout, overflow,
        input  edge_count, period_last, period_min, period_max
    );

    modport slave (
        input  clk_in, start, gate_len,
        output rise_stb, fall_stb, busy, done, timeout, overflow,
        output edge_count, period_last, period_min, period_max
    );
endinterface

// File: rtl/derived_clock_monitor.sv
// Edge strobes plus gated rise-count / period measurement of the clk-synchronous
// divider output level.
module derived_clock_monitor #(
    parameter int CW = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    derived_clock_monitor_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARM     = 2'd1,
        S_MEASURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [CW-1:0] ZERO = '0;
    localparam logic [CW-1:0] ONES = '1;
    localparam logic [CW-1:0] ONE  = {{(CW-1){1'b0}}, 1'b1};

    state_t        state_r;
    logic          prev_r;
    logic [CW-1:0] gate_r;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] pcnt_r;
    logic          rise_stb_r;
    logic          fall_stb_r;
    logic          busy_r;
    logic          done_r;
    logic          timeout_r;
    logic          overflow_r;
    logic [CW-1:0] edge_count_r;
    logic [CW-1:0] period_last_r;
    logic [CW-1:0] period_min_r;
    logic [CW-1:0] period_max_r;
    logic          rise_s;
    logic          fall_s;

    // Edge detection against the previous-cycle level
    always_comb begin
        rise_s = bus.clk_in & ~prev_r;
        fall_s = ~bus.clk_in & prev_r;
    end

    // Strobes, measurement FSM and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= S_IDLE;
            prev_r        <= 1'b1;
            gate_r        <= ZERO;
            cnt_r         <= ZERO;
            pcnt_r        <= ZERO;
            rise_stb_r    <= 1'b0;
            fall_stb_r    <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            timeout_r     <= 1'b0;
            overflow_r    <= 1'b0;
            edge_count_r  <= ZERO;
            period_last_r <= ZERO;
            period_min_r  <= ONES;
            period_max_r  <= ZERO;
        end else begin
            prev_r     <= bus.clk_in;
            rise_stb_r <= rise_s;
            fall_stb_r <= fall_s;
            done_r     <= 1'b0;
            case (state_r)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        gate_r        <= bus.gate_len;
                        cnt_r         <= ZERO;
                        timeout_r     <= 1'b0;
                        overflow_r    <= 1'b0;
                        edge_count_r  <= ZERO;
                        period_last_r <= ZERO;
                        period_min_r  <= ONES;
                        period_max_r  <= ZERO;
                        if (bus.gate_len == ZERO) begin
                            state_r <= S_DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= S_ARM;
                            busy_r  <= 1'b1;
                        end
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_ARM: begin
                    // The arming rise only opens the window; it is never counted
                    if (rise_s) begin
                        state_r <= S_MEASURE;
                        cnt_r   <= ONE;
                        pcnt_r  <= ONE;
                    end else if (cnt_r == gate_r - ONE) begin
                        state_r   <= S_DONE;
                        busy_r    <= 1'b0;
                        done_r    <= 1'b1;
                        timeout_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + ONE;
                    end
                end
                S_MEASURE: begin
                    if (pcnt_r == ONES) begin
                        overflow_r <= 1'b1;
                    end
                    if (rise_s) begin
                        if (edge_count_r == ONES) begin
                            overflow_r <= 1'b1;
                        end else begin
                            edge_count_r <= edge_count_r + ONE;
                        end
                        period_last_r <= pcnt_r;
                        if (pcnt_r < period_min_r) begin
                            period_min_r <= pcnt_r;
                        end
                        if (pcnt_r > period_max_r) begin
                            period_max_r <= pcnt_r;
                        end
                        pcnt_r <= ONE;
                    end else if (pcnt_r != ONES) begin
                        pcnt_r <= pcnt_r + ONE;
                    end
                    // cnt_r numbers the window cycles 1..gate_len
                    if (cnt_r == gate_r) begin
                        state_r <= S_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + ONE;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rise_stb    = rise_stb_r;
    assign bus.fall_stb    = fall_stb_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.timeout     = timeout_r;
    assign bus.overflow    = overflow_r;
    assign bus.edge_count  = edge_count_r;
    assign bus.period_last = period_last_r;
    assign bus.period_min  = period_min_r;
    assign bus.period_max  = period_max_r;
endmodule

// File: tb/tb_derived_clock_monitor.sv
// Scoreboard bench: a 32-bit and an 8-bit monitor share one clk_in waveform;
// expectations come from a waveform-level model and are checked when done pulses.
module tb_derived_clock_monitor;
    localparam int MAXC = 6000;

    typedef struct {
        int          inst;
        int          done_cyc;
        int          arm_cyc;
        logic [31:0] edge_cnt;
        logic [31:0] last;
        logic [31:0] pmin;
        logic [31:0] pmax;
        logic        timeout;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    bit   wave [MAXC];
    bit   rstc [MAXC];
    bit   busy32_e [MAXC];
    bit   busy8_e [MAXC];
    exp_t exp_q [$];

    derived_clock_monitor_if #(.CW(32)) bus32 ();
    derived_clock_monitor_if #(.CW(8))  bus8 ();

    derived_clock_monitor #(.CW(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
    derived_clock_monitor #(.CW(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit is_rise(int c);
        if (c < 1 || c >= MAXC) return 1'b0;
        return wave[c] && !wave[c-1];
    endfunction

    function automatic bit is_fall(int c);
        if (c < 1 || c >= MAXC) return 1'b0;
        return !wave[c] && wave[c-1];
    endfunction

    // Reference: scan the waveform for the arming rise, then measure rise gaps
    function automatic exp_t model(int s, int g, int inst);
        exp_t   e;
        longint ones;
        longint p;
        int     a;
        int     lr;
        ones       = (inst == 1) ? 64'd255 : 64'hFFFF_FFFF;
        e.inst     = inst;
        e.arm_cyc  = -1;
        e.edge_cnt = 32'd0;
        e.last     = 32'd0;
        e.pmin     = ones[31:0];
        e.pmax     = 32'd0;
        e.timeout  = 1'b0;
        e.ovf      = 1'b0;
        if (g == 0) begin
            e.done_cyc = s + 1;
            return e;
        end
        a = -1;
        for (int c = s + 1; c <= s + g && a < 0; c++) if (is_rise(c)) a = c;
        if (a < 0) begin
            e.timeout  = 1'b1;
            e.done_cyc = s + g + 1;
            return e;
        end
        e.arm_cyc = a;
        lr = a;
        for (int c = a + 1; c <= a + g; c++) begin
            p = longint'(c - lr);
            if (p >= ones) begin
                p     = ones;
                e.ovf = 1'b1;
            end
            if (is_rise(c)) begin
                if (e.edge_cnt == ones[31:0]) e.ovf = 1'b1;
                else e.edge_cnt = e.edge_cnt + 32'd1;
                e.last = p[31:0];
                if (p < longint'(e.pmin)) e.pmin = p[31:0];
                if (p > longint'(e.pmax)) e.pmax = p[31:0];
                lr = c;
            end
        end
        e.done_cyc = a + g + 1;
        return e;
    endfunction

    task automatic setw(int i, bit v);
        if (i < MAXC) wave[i] = v;
    endtask

    task automatic fill(int from, int pre, int len, int h0, int l0, int h1, int l1, bit rnd);
        int i = from;
        int k = 0;
        int h;
        int l;
        for (int j = 0; j < pre; j++) begin setw(i, 1'b0); i++; end
        while (i < from + len) begin
            if (rnd) begin h = $urandom_range(1, 5); l = $urandom_range(1, 5); end
            else if (k % 2 == 0) begin h = h0; l = l0; end
            else begin h = h1; l = l1; end
            for (int j = 0; j < h; j++) begin setw(i, 1'b1); i++; end
            for (int j = 0; j < l; j++) begin setw(i, 1'b0); i++; end
            k++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        bus32.clk_in = wave[cyc];
        bus8.clk_in  = wave[cyc];
        bus32.start  = 1'b0;
        bus8.start   = 1'b0;
    endtask

    task automatic check_rst();
        chk("rst_rise32", {31'd0, bus32.rise_stb}, 32'd0);
        chk("rst_fall32", {31'd0, bus32.fall_stb}, 32'd0);
        chk("rst_busy32", {31'd0, bus32.busy}, 32'd0);
        chk("rst_done32", {31'd0, bus32.done}, 32'd0);
        chk("rst_tmo32", {31'd0, bus32.timeout}, 32'd0);
        chk("rst_ovf32", {31'd0, bus32.overflow}, 32'd0);
        chk("rst_edge32", bus32.edge_count, 32'd0);
        chk("rst_last32", bus32.period_last, 32'd0);
        chk("rst_min32", bus32.period_min, 32'hFFFF_FFFF);
        chk("rst_max32", bus32.period_max, 32'd0);
        chk("rst_busy8", {31'd0, bus8.busy}, 32'd0);
        chk("rst_edge8", {24'd0, bus8.edge_count}, 32'd0);
        chk("rst_min8", {24'd0, bus8.period_min}, 32'd255);
        chk("rst_max8", {24'd0, bus8.period_max}, 32'd0);
    endtask

    task automatic scen(int inst, int g, int pre, int h0, int l0, int h1, int l1,
                        bit rnd, int mid_start, int rst_at);
        exp_t e;
        fill(cyc + 1, pre, 2 * g + 400, h0, l0, h1, l1, rnd);
        tick();
        if (inst == 1) begin bus8.gate_len = g[7:0]; bus8.start = 1'b1; end
        else begin bus32.gate_len = g; bus32.start = 1'b1; end
        e = model(cyc, g, inst);
        exp_q.push_back(e);
        for (int c = cyc + 1; c < e.done_cyc && c < MAXC; c++) begin
            if (inst == 1) busy8_e[c] = 1'b1;
            else busy32_e[c] = 1'b1;
        end
        while (cyc < e.done_cyc + 3) begin
            tick();
            if (mid_start > 0 && cyc == e.arm_cyc + mid_start) begin
                bus32.gate_len = 32'd5;
                bus32.start    = 1'b1;
            end
            if (rst_at > 0 && cyc == e.arm_cyc + rst_at) begin
                wave[cyc+1] = 1'b1;
                rstc[cyc+1] = 1'b1;
                for (int c = cyc + 2; c < MAXC; c++) begin
                    busy32_e[c] = 1'b0;
                    busy8_e[c]  = 1'b0;
                end
                void'(exp_q.pop_back());
                tick();
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
                check_rst();
                break;
            end
        end
    endtask

    // Monitor: strobes and busy every cycle, results whenever done pulses
    always @(negedge clk) begin
        if (cyc >= 1 && cyc < MAXC) begin
            chk("rise_stb", {31'd0, bus32.rise_stb}, {31'd0, !rstc[cyc-1] && is_rise(cyc-1)});
            chk("fall_stb", {31'd0, bus32.fall_stb}, {31'd0, !rstc[cyc-1] && is_fall(cyc-1)});
            chk("rise_stb8", {31'd0, bus8.rise_stb}, {31'd0, !rstc[cyc-1] && is_rise(cyc-1)});
            chk("busy32", {31'd0, bus32.busy}, {31'd0, busy32_e[cyc]});
            chk("busy8", {31'd0, bus8.busy}, {31'd0, busy8_e[cyc]});
            for (int k = 0; k < 2; k++) begin
                if ((k == 0 && bus32.done) || (k == 1 && bus8.done)) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: inst %0d pulsed done, none expected (cycle %0d)", k, cyc);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("done_inst", k, e.inst);
                        chk("done_cycle", cyc, e.done_cyc);
                        if (k == 0) begin
                            chk("edge_count", bus32.edge_count, e.edge_cnt);
                            chk("period_last", bus32.period_last, e.last);
                            chk("period_min", bus32.period_min, e.pmin);
                            chk("period_max", bus32.period_max, e.pmax);
                            chk("timeout", {31'd0, bus32.timeout}, {31'd0, e.timeout});
                            chk("overflow", {31'd0, bus32.overflow}, {31'd0, e.ovf});
                        end else begin
                            chk("edge_count8", {24'd0, bus8.edge_count}, e.edge_cnt);
                            chk("period_last8", {24'd0, bus8.period_last}, e.last);
                            chk("period_min8", {24'd0, bus8.period_min}, e.pmin);
                            chk("period_max8", {24'd0, bus8.period_max}, e.pmax);
                            chk("timeout8", {31'd0, bus8.timeout}, {31'd0, e.timeout});
                            chk("overflow8", {31'd0, bus8.overflow}, {31'd0, e.ovf});
                        end
                    end
                end
            end
            if (exp_q.size() > 0 && cyc > exp_q[0].done_cyc) begin
                checks++;
                errors++;
                $display("FAIL done_missing: no done by cycle %0d, expected at %0d", cyc, exp_q[0].done_cyc);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        for (int c = 0; c < 4; c++) wave[c] = 1'b1;
        for (int c = 0; c < 3; c++) rstc[c] = 1'b1;
        bus32.clk_in = 1'b1;  bus8.clk_in = 1'b1;
        bus32.start = 1'b0;   bus8.start = 1'b0;
        bus32.gate_len = 32'd0; bus8.gate_len = 8'd0;
        tick(); tick(); tick();
        rst_n = 1'b1;
        check_rst();
        scen(0, 40, 3, 2, 2, 2, 2, 1'b0, 0, 0);
        scen(0, 70, 3, 2, 1, 2, 2, 1'b0, 0, 0);
        scen(0, 100, 0, 1000, 1, 1000, 1, 1'b0, 0, 0);
        scen(0, 40, 3, 2, 2, 2, 2, 1'b0, 12, 0);
        scen(0, 0, 3, 2, 2, 2, 2, 1'b0, 0, 0);
        scen(1, 0, 3, 2, 2, 2, 2, 1'b0, 0, 0);
        scen(0, 40, 3, 2, 2, 2, 2, 1'b0, 0, 15);
        scen(0, 40, 3, 2, 2, 2, 2, 1'b0, 0, 0);
        scen(1, 250, 3, 150, 150, 150, 150, 1'b0, 0, 0);
        scen(1, 255, 3, 130, 130, 130, 130, 1'b0, 0, 0);
        for (int r = 0; r < 4; r++) begin
            scen(0, $urandom_range(20, 120), $urandom_range(1, 4), 0, 0, 0, 0, 1'b1, 0, 0);
        end
        scen(1, $urandom_range(20, 200), 2, 0, 0, 0, 0, 1'b1, 0, 0);
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_results: %0d expected results never reported, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
